// File: rtl/turn_controller.sv
// Tic-tac-toe turn controller: validates move requests against a 9-cell board,
// issues a one-cycle write strobe to the cell-enable decoder, then checks the
// mover's lines for a win or a full-board draw before handing over the turn.
module turn_controller #(
  parameter bit FIRST_PLAYER = 1'b0  // 0 = X moves first, 1 = O moves first
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic [3:0] sel,
  output logic       wr_en,
  output logic       wr_mark,
  output logic       turn,
  output logic       move_ack,
  output logic       move_err,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {StIdle, StWrite, StCheck, StDone} state_e;

  state_e     state_q, state_d;
  logic [8:0] occupied_q, occupied_d;
  logic [8:0] owner_q, owner_d;
  logic [3:0] sel_q, sel_d;
  logic       wr_en_q, wr_en_d;
  logic       wr_mark_q, wr_mark_d;
  logic       turn_q, turn_d;
  logic       move_ack_q, move_ack_d;
  logic       move_err_q, move_err_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;

  logic [8:0] req_bit;
  logic [8:0] sel_bit;
  logic [8:0] mine;
  logic       req_ok;
  logic       line_done;

  // True when any row, column or diagonal of m is fully set.
  function automatic logic any_line(input logic [8:0] m);
    any_line = (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  // Request decode and line evaluation for the player in turn.
  always_comb begin
    req_bit   = 9'd1 << move_pos;  // shifts out to zero for positions above 8
    sel_bit   = 9'd1 << sel_q;
    req_ok    = (move_pos <= 4'd8) && ((occupied_q & req_bit) == 9'd0);
    mine      = occupied_q & (turn_q ? owner_q : ~owner_q);
    line_done = any_line(mine);
  end

  // Next-state and registered-output values; new_game overrides everything.
  always_comb begin
    state_d     = state_q;
    occupied_d  = occupied_q;
    owner_d     = owner_q;
    sel_d       = sel_q;
    wr_en_d     = 1'b0;
    wr_mark_d   = wr_mark_q;
    turn_d      = turn_q;
    move_ack_d  = 1'b0;
    move_err_d  = 1'b0;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    if (new_game) begin
      state_d     = StIdle;
      occupied_d  = 9'd0;
      owner_d     = 9'd0;
      turn_d      = FIRST_PLAYER;
      game_over_d = 1'b0;
      winner_d    = 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (move_valid) begin
            if (req_ok) begin
              sel_d      = move_pos;
              wr_en_d    = 1'b1;
              move_ack_d = 1'b1;
              wr_mark_d  = turn_q;
              state_d    = StWrite;
            end else begin
              move_err_d = 1'b1;
            end
          end
        end
        StWrite: begin
          occupied_d = occupied_q | sel_bit;
          owner_d    = turn_q ? (owner_q | sel_bit) : (owner_q & ~sel_bit);
          state_d    = StCheck;
        end
        StCheck: begin
          if (line_done) begin
            winner_d    = turn_q ? 2'b10 : 2'b01;
            game_over_d = 1'b1;
            state_d     = StDone;
          end else if (&occupied_q) begin
            winner_d    = 2'b11;
            game_over_d = 1'b1;
            state_d     = StDone;
          end else begin
            turn_d  = ~turn_q;
            state_d = StIdle;
          end
        end
        StDone: begin
          if (move_valid) move_err_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      occupied_q  <= 9'd0;
      owner_q     <= 9'd0;
      sel_q       <= 4'd0;
      wr_en_q     <= 1'b0;
      wr_mark_q   <= 1'b0;
      turn_q      <= FIRST_PLAYER;
      move_ack_q  <= 1'b0;
      move_err_q  <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      occupied_q  <= occupied_d;
      owner_q     <= owner_d;
      sel_q       <= sel_d;
      wr_en_q     <= wr_en_d;
      wr_mark_q   <= wr_mark_d;
      turn_q      <= turn_d;
      move_ack_q  <= move_ack_d;
      move_err_q  <= move_err_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign sel       = sel_q;
  assign wr_en     = wr_en_q;
  assign wr_mark   = wr_mark_q;
  assign turn      = turn_q;
  assign move_ack  = move_ack_q;
  assign move_err  = move_err_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: each task drives one scenario and checks
// outputs against hand-computed values one time unit after the rising edge.
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic [3:0] sel;
  logic       wr_en, wr_mark, turn, move_ack, move_err, game_over;
  logic [1:0] winner;

  int vectors = 0;
  int miscompares = 0;

  turn_controller #(.FIRST_PLAYER(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .new_game  (new_game),
    .move_valid(move_valid),
    .move_pos  (move_pos),
    .sel       (sel),
    .wr_en     (wr_en),
    .wr_mark   (wr_mark),
    .turn      (turn),
    .move_ack  (move_ack),
    .move_err  (move_err),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request a move and wait through WRITE and CHECK.
  task automatic play(input logic [3:0] pos);
    move_valid = 1'b1;
    move_pos   = pos;
    step();
    move_valid = 1'b0;
    step();
    step();
  endtask

  task automatic restart();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({sel, wr_en, wr_mark, turn, move_ack, move_err, game_over, winner} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got sel=%0d wr_en=%b wr_mark=%b turn=%b ack=%b err=%b go=%b win=%b want all zero",
               sel, wr_en, wr_mark, turn, move_ack, move_err, game_over, winner);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_move();
    move_valid = 1'b1;
    move_pos   = 4'd4;
    step();
    move_valid = 1'b0;
    vectors++;
    if ({sel, wr_en, wr_mark, move_ack, move_err} !== {4'd4, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL first_write: got sel=%0d wr_en=%b mark=%b ack=%b err=%b want 4 1 0 1 0",
               sel, wr_en, wr_mark, move_ack, move_err);
    end
    step();
    vectors++;
    if ({wr_en, move_ack, turn} !== 3'b000) begin
      miscompares++;
      $display("FAIL first_check_cycle: got wr_en=%b ack=%b turn=%b want 0 0 0", wr_en, move_ack, turn);
    end
    step();
    vectors++;
    if ({turn, game_over} !== 2'b10) begin
      miscompares++;
      $display("FAIL first_turn: got turn=%b go=%b want 1 0", turn, game_over);
    end
  endtask

  task automatic test_occupied();
    move_valid = 1'b1;
    move_pos   = 4'd4;
    step();
    move_valid = 1'b0;
    vectors++;
    if ({move_err, wr_en, move_ack} !== 3'b100) begin
      miscompares++;
      $display("FAIL occupied_err: got err=%b wr_en=%b ack=%b want 1 0 0", move_err, wr_en, move_ack);
    end
    step();
    vectors++;
    if ({move_err, turn} !== 2'b01) begin
      miscompares++;
      $display("FAIL occupied_after: got err=%b turn=%b want 0 1", move_err, turn);
    end
    // O now takes cell 0 legitimately.
    move_valid = 1'b1;
    move_pos   = 4'd0;
    step();
    move_valid = 1'b0;
    vectors++;
    if ({sel, wr_en, wr_mark, move_ack} !== {4'd0, 1'b1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL o_write: got sel=%0d wr_en=%b mark=%b ack=%b want 0 1 1 1",
               sel, wr_en, wr_mark, move_ack);
    end
    step();
    step();
    vectors++;
    if (turn !== 1'b0) begin
      miscompares++;
      $display("FAIL o_turn: got turn=%b want 0", turn);
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] bad [2] = '{4'd9, 4'd15};
    for (int i = 0; i < 2; i++) begin
      move_valid = 1'b1;
      move_pos   = bad[i];
      step();
      move_valid = 1'b0;
      vectors++;
      if ({move_err, wr_en, move_ack} !== 3'b100) begin
        miscompares++;
        $display("FAIL range_err_%0d: got err=%b wr_en=%b ack=%b want 1 0 0",
                 bad[i], move_err, wr_en, move_ack);
      end
      step();
      vectors++;
      if ({move_err, turn, sel} !== {1'b0, 1'b0, 4'd0}) begin
        miscompares++;
        $display("FAIL range_after_%0d: got err=%b turn=%b sel=%0d want 0 0 0",
                 bad[i], move_err, turn, sel);
      end
    end
  endtask

  task automatic test_ignore_busy();
    move_valid = 1'b1;
    move_pos   = 4'd8;
    step();
    move_pos = 4'd7;  // arrives during WRITE
    step();
    vectors++;
    if ({move_ack, move_err, wr_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL write_ignore: got ack=%b err=%b wr_en=%b want 0 0 0", move_ack, move_err, wr_en);
    end
    move_pos = 4'd9;  // arrives during CHECK
    step();
    move_valid = 1'b0;
    vectors++;
    if ({move_ack, move_err, turn, sel} !== {1'b0, 1'b0, 1'b1, 4'd8}) begin
      miscompares++;
      $display("FAIL check_ignore: got ack=%b err=%b turn=%b sel=%0d want 0 0 1 8",
               move_ack, move_err, turn, sel);
    end
    step();
  endtask

  task automatic test_x_win();
    restart();
    play(4'd0); play(4'd3); play(4'd1); play(4'd4);
    vectors++;
    if ({game_over, winner} !== 3'b000) begin
      miscompares++;
      $display("FAIL x_win_early: got go=%b win=%b want 0 00", game_over, winner);
    end
    play(4'd2);
    vectors++;
    if ({game_over, winner} !== 3'b101) begin
      miscompares++;
      $display("FAIL x_win: got go=%b win=%b want 1 01", game_over, winner);
    end
    move_valid = 1'b1;
    move_pos   = 4'd5;
    step();
    move_valid = 1'b0;
    vectors++;
    if ({move_err, move_ack, wr_en, winner} !== 5'b10001) begin
      miscompares++;
      $display("FAIL done_err: got err=%b ack=%b wr_en=%b win=%b want 1 0 0 01",
               move_err, move_ack, wr_en, winner);
    end
    step();
    vectors++;
    if (move_err !== 1'b0) begin
      miscompares++;
      $display("FAIL done_err_pulse: got err=%b want 0", move_err);
    end
  endtask

  task automatic test_o_win();
    restart();
    play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd8); play(4'd5);
    vectors++;
    if ({game_over, winner, turn} !== 4'b1101) begin
      miscompares++;
      $display("FAIL o_win: got go=%b win=%b turn=%b want 1 10 1", game_over, winner, turn);
    end
  endtask

  task automatic test_draw();
    logic [3:0] seq [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
    restart();
    for (int i = 0; i < 9; i++) play(seq[i]);
    vectors++;
    if ({game_over, winner} !== 3'b111) begin
      miscompares++;
      $display("FAIL draw: got go=%b win=%b want 1 11", game_over, winner);
    end
    restart();
    vectors++;
    if ({game_over, winner, turn} !== 4'b0000) begin
      miscompares++;
      $display("FAIL draw_new_game: got go=%b win=%b turn=%b want 0 00 0", game_over, winner, turn);
    end
    move_valid = 1'b1;
    move_pos   = 4'd0;
    step();
    move_valid = 1'b0;
    vectors++;
    if ({move_ack, move_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL draw_cell_free: got ack=%b err=%b want 1 0", move_ack, move_err);
    end
    step();
    step();
  endtask

  task automatic test_ninth_move_win();
    logic [3:0] seq [9] = '{4'd0, 4'd2, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    restart();
    for (int i = 0; i < 9; i++) play(seq[i]);
    vectors++;
    if ({game_over, winner} !== 3'b101) begin
      miscompares++;
      $display("FAIL ninth_win: got go=%b win=%b want 1 01", game_over, winner);
    end
  endtask

  task automatic test_new_game_with_move();
    restart();
    play(4'd4); play(4'd2);
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_pos   = 4'd4;
    step();
    new_game   = 1'b0;
    move_valid = 1'b0;
    vectors++;
    if ({move_ack, move_err, wr_en, turn} !== 4'b0000) begin
      miscompares++;
      $display("FAIL ng_drop: got ack=%b err=%b wr_en=%b turn=%b want 0 0 0 0",
               move_ack, move_err, wr_en, turn);
    end
    move_valid = 1'b1;
    move_pos   = 4'd2;
    step();
    move_valid = 1'b0;
    vectors++;
    if ({move_ack, move_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL ng_cleared: got ack=%b err=%b want 1 0", move_ack, move_err);
    end
    step();
    step();
  endtask

  task automatic test_new_game_in_write();
    restart();
    move_valid = 1'b1;
    move_pos   = 4'd6;
    step();
    move_valid = 1'b0;
    new_game   = 1'b1;
    step();
    new_game = 1'b0;
    step();
    vectors++;
    if ({turn, game_over} !== 2'b00) begin
      miscompares++;
      $display("FAIL ng_write_turn: got turn=%b go=%b want 0 0", turn, game_over);
    end
    move_valid = 1'b1;
    move_pos   = 4'd6;
    step();
    move_valid = 1'b0;
    vectors++;
    if ({move_ack, move_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL ng_write_free: got ack=%b err=%b want 1 0", move_ack, move_err);
    end
    step();
    step();
  endtask

  task automatic test_reset_in_write();
    restart();
    move_valid = 1'b1;
    move_pos   = 4'd7;
    step();
    move_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({wr_en, move_ack, sel} !== {1'b0, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL rst_write_async: got wr_en=%b ack=%b sel=%0d want 0 0 0", wr_en, move_ack, sel);
    end
    #1;
    rst_n = 1'b1;
    step();
    step();
    move_valid = 1'b1;
    move_pos   = 4'd7;
    step();
    move_valid = 1'b0;
    vectors++;
    if ({move_ack, move_err, wr_mark} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_write_free: got ack=%b err=%b mark=%b want 1 0 0", move_ack, move_err, wr_mark);
    end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_occupied();
    test_out_of_range();
    test_ignore_busy();
    test_x_win();
    test_o_win();
    test_draw();
    test_ninth_move_win();
    test_new_game_with_move();
    test_new_game_in_write();
    test_reset_in_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
